// File: rtl/pipelined_shifter.sv
// Pipelined log shifter: SLL/SRL/SLA/SRA/ROL/ROR with valid/ready on both sides.
// Optional outputs zero_flag/carry_out are enabled by defining SHIFTER_FLAGS_EN.
module pipelined_shifter #(
  parameter int WIDTH       = 32,
  parameter int PIPE_STAGES = 2,
  localparam int SH_W       = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] shift_in,
  input  logic [SH_W-1:0]  SH,
  input  logic [2:0]       ftn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] shift_out
`ifdef SHIFTER_FLAGS_EN
  ,
  output logic             zero_flag,
  output logic             carry_out
`endif
);

  typedef enum logic [1:0] {OP_LEFT, OP_RIGHT, OP_ROTR} op_e;

  localparam int BASE  = SH_W / PIPE_STAGES;
  localparam int EXTRA = SH_W % PIPE_STAGES;

  // Earlier stages absorb the leftover levels when SH_W does not divide evenly.
  function automatic int lvl_lo(input int s);
    return s * BASE + ((s < EXTRA) ? s : EXTRA);
  endfunction

  function automatic int lvl_hi(input int s);
    return lvl_lo(s) + BASE + ((s < EXTRA) ? 1 : 0);
  endfunction

  function automatic logic [WIDTH-1:0] apply_levels(
    input logic [WIDTH-1:0] d,
    input logic [SH_W-1:0]  sh,
    input op_e              op,
    input logic             fill,
    input int               lo,
    input int               hi
  );
    logic [WIDTH-1:0] r;
    r = d;
    for (int k = 0; k < SH_W; k++) begin
      if (k >= lo && k < hi && sh[k]) begin
        case (op)
          OP_LEFT:  r = r << (1 << k);
          OP_RIGHT: r = (r >> (1 << k)) | (fill ? ~({WIDTH{1'b1}} >> (1 << k)) : '0);
          default:  r = (r >> (1 << k)) | (r << (WIDTH - (1 << k)));
        endcase
      end
    end
    return r;
  endfunction

  logic            advance;
  logic [SH_W-1:0] sh_entry;
  op_e             op_entry;
  logic            fill_entry;

  logic [WIDTH-1:0] data_q [PIPE_STAGES];
  logic [SH_W-1:0]  sh_q   [PIPE_STAGES];
  op_e              op_q   [PIPE_STAGES];
  logic             fill_q [PIPE_STAGES];
  logic             vld_q  [PIPE_STAGES];

  logic [WIDTH-1:0] stg_data [PIPE_STAGES];
  logic [SH_W-1:0]  stg_sh   [PIPE_STAGES];
  op_e              stg_op   [PIPE_STAGES];
  logic             stg_fill [PIPE_STAGES];
  logic             stg_vld  [PIPE_STAGES];
  logic [WIDTH-1:0] res      [PIPE_STAGES];

  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_q[PIPE_STAGES-1];
  assign shift_out = data_q[PIPE_STAGES-1];

  // ROL n is rewritten as ROR (WIDTH-n) mod WIDTH; pass codes shift by zero.
  always_comb begin
    op_entry = OP_LEFT;
    sh_entry = SH;
    case (ftn)
      3'b000, 3'b010: op_entry = OP_LEFT;
      3'b001, 3'b011: op_entry = OP_RIGHT;
      3'b100: begin
        op_entry = OP_ROTR;
        sh_entry = -SH;
      end
      3'b101:  op_entry = OP_ROTR;
      default: sh_entry = '0;
    endcase
    fill_entry = (ftn == 3'b011) && shift_in[WIDTH-1];
  end

  always_comb begin
    stg_data[0] = shift_in;
    stg_sh[0]   = sh_entry;
    stg_op[0]   = op_entry;
    stg_fill[0] = fill_entry;
    stg_vld[0]  = in_valid;
    for (int s = 1; s < PIPE_STAGES; s++) begin
      stg_data[s] = data_q[s-1];
      stg_sh[s]   = sh_q[s-1];
      stg_op[s]   = op_q[s-1];
      stg_fill[s] = fill_q[s-1];
      stg_vld[s]  = vld_q[s-1];
    end
    for (int s = 0; s < PIPE_STAGES; s++) begin
      res[s] = apply_levels(stg_data[s], stg_sh[s], stg_op[s], stg_fill[s],
                            lvl_lo(s), lvl_hi(s));
    end
  end

  // Payload only moves with a valid token so shift_out holds across bubbles.
  for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q[s]  <= 1'b0;
        data_q[s] <= '0;
        sh_q[s]   <= '0;
        op_q[s]   <= OP_LEFT;
        fill_q[s] <= 1'b0;
      end else if (advance) begin
        vld_q[s] <= stg_vld[s];
        if (stg_vld[s]) begin
          data_q[s] <= res[s];
          sh_q[s]   <= stg_sh[s];
          op_q[s]   <= stg_op[s];
          fill_q[s] <= stg_fill[s];
        end
      end
    end
  end

`ifdef SHIFTER_FLAGS_EN
  logic [SH_W-1:0] idx_left;
  logic [SH_W-1:0] idx_right;
  logic            carry_entry;
  logic            carry_q   [PIPE_STAGES];
  logic            stg_carry [PIPE_STAGES];
  logic            zero_q;

  // Last bit shifted out is known from the operand alone, so it rides the pipe.
  always_comb begin
    idx_left    = -SH;
    idx_right   = SH - 1'b1;
    carry_entry = 1'b0;
    if (SH != '0) begin
      case (ftn)
        3'b000, 3'b010, 3'b100: carry_entry = shift_in[idx_left];
        3'b001, 3'b011, 3'b101: carry_entry = shift_in[idx_right];
        default:                carry_entry = 1'b0;
      endcase
    end
    stg_carry[0] = carry_entry;
    for (int s = 1; s < PIPE_STAGES; s++) stg_carry[s] = carry_q[s-1];
  end

  for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_carry
    always_ff @(posedge clk) begin
      if (rst) carry_q[s] <= 1'b0;
      else if (advance && stg_vld[s]) carry_q[s] <= stg_carry[s];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) zero_q <= 1'b0;
    else if (advance && stg_vld[PIPE_STAGES-1]) zero_q <= (res[PIPE_STAGES-1] == '0);
  end

  assign zero_flag = zero_q;
  assign carry_out = carry_q[PIPE_STAGES-1];
`endif

endmodule

// File: tb/tb_pipelined_shifter.sv
// Bench for pipelined_shifter: W32/P2, W64/P1 and W64/P6 instances with scoreboards.
// Flag outputs are checked when SHIFTER_FLAGS_EN is defined.
module tb_pipelined_shifter;

  typedef struct {
    logic [63:0] data;
    logic        z;
    logic        c;
    int          acc;
    int          lat;
  } sb_t;

  typedef struct {
    logic [63:0] d;
    int          s;
    logic [2:0]  f;
    logic [63:0] exp;
  } vec_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_pass;

  logic        in_valid [3];
  logic        out_rdy  [3];
  logic [63:0] din      [3];
  logic [5:0]  sh       [3];
  logic [2:0]  ftn      [3];
  logic        in_rdy   [3];
  logic        out_vld  [3];
  logic [63:0] dout     [3];
  logic        zf       [3];
  logic        co       [3];

  logic        ir0, ir1, ir2, ov0, ov1, ov2;
  logic [31:0] so0;
  logic [63:0] so1, so2;

  sb_t  sbq [3][$];
  vec_t tbl [19];

  pipelined_shifter #(.WIDTH(32), .PIPE_STAGES(2)) u_w32 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(ir0),
    .shift_in(din[0][31:0]), .SH(sh[0][4:0]), .ftn(ftn[0]),
    .out_valid(ov0), .out_ready(out_rdy[0]), .shift_out(so0)
`ifdef SHIFTER_FLAGS_EN
    , .zero_flag(zf[0]), .carry_out(co[0])
`endif
  );

  pipelined_shifter #(.WIDTH(64), .PIPE_STAGES(1)) u_w64_p1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(ir1),
    .shift_in(din[1]), .SH(sh[1]), .ftn(ftn[1]),
    .out_valid(ov1), .out_ready(out_rdy[1]), .shift_out(so1)
`ifdef SHIFTER_FLAGS_EN
    , .zero_flag(zf[1]), .carry_out(co[1])
`endif
  );

  pipelined_shifter #(.WIDTH(64), .PIPE_STAGES(6)) u_w64_p6 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(ir2),
    .shift_in(din[2]), .SH(sh[2]), .ftn(ftn[2]),
    .out_valid(ov2), .out_ready(out_rdy[2]), .shift_out(so2)
`ifdef SHIFTER_FLAGS_EN
    , .zero_flag(zf[2]), .carry_out(co[2])
`endif
  );

  assign in_rdy[0]  = ir0;
  assign in_rdy[1]  = ir1;
  assign in_rdy[2]  = ir2;
  assign out_vld[0] = ov0;
  assign out_vld[1] = ov1;
  assign out_vld[2] = ov2;
  assign dout[0]    = {32'h0, so0};
  assign dout[1]    = so1;
  assign dout[2]    = so2;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] model(input int w, input logic [63:0] d, input int s,
                                        input logic [2:0] f);
    logic [63:0] r;
    logic        msb;
    r   = '0;
    msb = d[w-1];
    for (int i = 0; i < w; i++) begin
      case (f)
        3'b000, 3'b010: r[i] = (i >= s) ? d[i-s] : 1'b0;
        3'b001:         r[i] = (i + s < w) ? d[i+s] : 1'b0;
        3'b011:         r[i] = (i + s < w) ? d[i+s] : msb;
        3'b100:         r[i] = d[(i - s + w) % w];
        3'b101:         r[i] = d[(i + s) % w];
        default:        r[i] = d[i];
      endcase
    end
    return r;
  endfunction

  function automatic logic model_carry(input int w, input logic [63:0] d, input int s,
                                       input logic [2:0] f, input logic [63:0] r);
    if (s == 0 || f[2:1] == 2'b11) return 1'b0;
    case (f)
      3'b000, 3'b010: return d[w-s];
      3'b001, 3'b011: return d[s-1];
      3'b100:         return r[0];
      default:        return r[w-1];
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic send(input int ch, input logic [63:0] d, input int s, input logic [2:0] f,
                      input logic [63:0] exp, input int lat);
    sb_t e;
    int  w;
    int  t;
    w = (ch == 0) ? 32 : 64;
    din[ch]      = d;
    sh[ch]       = 6'(s);
    ftn[ch]      = f;
    in_valid[ch] = 1'b1;
    t = 0;
    while (!in_rdy[ch] && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_rdy[ch]) begin
      n_checks++;
      $display("FAIL send_timeout ch%0d: in_ready got 0 expected 1", ch);
      in_valid[ch] = 1'b0;
      return;
    end
    e.data = exp;
    e.z    = (exp == 64'h0);
    e.c    = model_carry(w, d, s, f, exp);
    e.acc  = cyc;
    e.lat  = lat;
    sbq[ch].push_back(e);
    @(negedge clk);
    in_valid[ch] = 1'b0;
  endtask

  always @(negedge clk) begin
    for (int ch = 0; ch < 3; ch++) begin
      if (!rst && out_vld[ch] && out_rdy[ch]) begin
        if (sbq[ch].size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_out ch%0d: got %0h expected no result", ch, dout[ch]);
        end else begin
          sb_t e;
          e = sbq[ch].pop_front();
          chk($sformatf("data_ch%0d", ch), dout[ch], e.data);
          if (e.lat >= 0) chk($sformatf("latency_ch%0d", ch), 64'(cyc - e.acc), 64'(e.lat));
`ifdef SHIFTER_FLAGS_EN
          chk($sformatf("zero_flag_ch%0d", ch), 64'(zf[ch]), 64'(e.z));
          chk($sformatf("carry_out_ch%0d", ch), 64'(co[ch]), 64'(e.c));
`endif
        end
      end
    end
  end

  initial begin
    logic [63:0] r;
    logic [63:0] held;
    int          s;
    logic [2:0]  f;
    int          t;

    cyc = 0;
    n_checks = 0;
    n_pass = 0;
    rst = 1'b1;
    for (int ch = 0; ch < 3; ch++) begin
      in_valid[ch] = 1'b0;
      out_rdy[ch]  = 1'b1;
      din[ch]      = '0;
      sh[ch]       = '0;
      ftn[ch]      = '0;
    end

    tbl[0]  = '{64'h80000001, 4, 3'b000, 64'h00000010};
    tbl[1]  = '{64'h80000001, 4, 3'b001, 64'h08000000};
    tbl[2]  = '{64'h80000001, 4, 3'b011, 64'hF8000000};
    tbl[3]  = '{64'h80000001, 4, 3'b100, 64'h00000018};
    tbl[4]  = '{64'h80000001, 4, 3'b101, 64'h18000000};
    for (int i = 0; i < 8; i++) tbl[5+i] = '{64'hDEADBEEF, 0, 3'(i), 64'hDEADBEEF};
    tbl[13] = '{64'h80000000, 31, 3'b011, 64'hFFFFFFFF};
    tbl[14] = '{64'h00000001, 31, 3'b100, 64'h80000000};
    tbl[15] = '{64'h12345678, 7, 3'b111, 64'h12345678};
    tbl[16] = '{64'h80000000, 1, 3'b000, 64'h00000000};
    tbl[17] = '{64'h00000002, 2, 3'b001, 64'h00000000};
    tbl[18] = '{64'h80000001, 4, 3'b010, 64'h00000010};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int ch = 0; ch < 3; ch++) begin
      chk($sformatf("rst_out_valid_ch%0d", ch), 64'(out_vld[ch]), 64'h0);
      chk($sformatf("rst_shift_out_ch%0d", ch), dout[ch], 64'h0);
      chk($sformatf("rst_in_ready_ch%0d", ch), 64'(in_rdy[ch]), 64'h1);
    end

    // Directed vectors, back to back, latency 2.
    for (int i = 0; i < 19; i++) send(0, tbl[i].d, tbl[i].s, tbl[i].f, tbl[i].exp, 2);

    for (int i = 0; i < 30; i++) begin
      r = {32'h0, $urandom()};
      s = $urandom_range(0, 31);
      f = 3'($urandom_range(0, 7));
      send(0, r, s, f, model(32, r, s, f), 2);
    end
    for (int ch = 1; ch < 3; ch++) begin
      for (int i = 0; i < 40; i++) begin
        r = {$urandom(), $urandom()};
        s = $urandom_range(0, 63);
        f = 3'($urandom_range(0, 7));
        send(ch, r, s, f, model(64, r, s, f), (ch == 1) ? 1 : 6);
      end
    end
    repeat (10) @(negedge clk);

    // Stall: three back-to-back operands, plus a fourth offered during the stall.
    held = model(32, 64'h0000F00D, 3, 3'b000);
    fork
      begin
        send(0, 64'h0000ABCD, 8, 3'b000, 64'h00ABCD00, -1);
        send(0, 64'h0000F00D, 3, 3'b000, held, -1);
        send(0, 64'hC0000000, 4, 3'b011, 64'hFC000000, -1);
        send(0, 64'h00000003, 1, 3'b101, 64'h80000001, -1);
      end
      begin
        t = 0;
        while (!out_vld[0] && t < 50) begin
          @(negedge clk);
          t++;
        end
        chk("stall_first_valid", 64'(out_vld[0]), 64'h1);
        @(posedge clk);
        #1 out_rdy[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("stall_in_ready", 64'(in_rdy[0]), 64'h0);
          chk("stall_out_valid", 64'(out_vld[0]), 64'h1);
          chk("stall_shift_out", dout[0], held);
        end
        @(posedge clk);
        #1 out_rdy[0] = 1'b1;
      end
    join
    repeat (10) @(negedge clk);
    chk("stall_all_delivered", 64'(sbq[0].size()), 64'h0);

    // Reset with two operands in flight: neither may ever appear.
    out_rdy[0] = 1'b0;
    send(0, 64'h11111111, 1, 3'b000, 64'h22222222, -1);
    send(0, 64'h44444444, 2, 3'b001, 64'h11111111, -1);
    rst = 1'b1;
    sbq[0].delete();
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_out_valid", 64'(out_vld[0]), 64'h0);
    chk("midrst_shift_out", dout[0], 64'h0);
    chk("midrst_in_ready", 64'(in_rdy[0]), 64'h1);
    out_rdy[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midrst_no_result", 64'(out_vld[0]), 64'h0);
    end

    // Pipeline still usable after the mid-flight reset.
    send(0, 64'h0F0F0F0F, 4, 3'b100, 64'hF0F0F0F0, 2);
    t = 0;
    while ((sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    for (int ch = 0; ch < 3; ch++)
      chk($sformatf("drain_ch%0d", ch), 64'(sbq[ch].size()), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
